// File: rtl/ysyx_25030093_mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with a hung-slave watchdog.
// Define ARB_RR_EN for round-robin grant; by default LSU has fixed priority over IFU.
module ysyx_25030093_mem_arb #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                err_timeout
);

   localparam int MASK_W = DATA_W / 8;
   localparam int WDOG_W = $clog2(TIMEOUT_CYC);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} own_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } mreq_t;

   state_t            state_q, state_d;
   own_t              owner_q, owner_d;
   own_t              last_q, last_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              err_q, err_d;

   logic  in_req, in_resp, own_lsu;
   logic  owner_resp_ready;
   logic  req_hs, resp_hs, wdog_hit;
   logic  grant_lsu;
   mreq_t mreq;

   assign in_req           = (state_q == REQ);
   assign in_resp          = (state_q == RESP);
   assign own_lsu          = (owner_q == OWN_LSU);
   assign owner_resp_ready = own_lsu ? lsu_resp_ready : ifu_resp_ready;
   assign req_hs           = in_req && mem_req_ready;
   assign resp_hs          = in_resp && mem_resp_valid && owner_resp_ready;
   assign wdog_hit         = (wdog_q == WDOG_MAX);

`ifdef ARB_RR_EN
   // On a tie the master that did not finish the last transaction wins.
   assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OWN_IFU));
`else
   assign grant_lsu = lsu_req_valid;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = err_q;
      wdog_d  = '0;
      case (state_q)
         IDLE: begin
            if (ifu_req_valid || lsu_req_valid) begin
               owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
               state_d = REQ;
            end
         end
         REQ: begin
            if (req_hs) state_d = RESP;
         end
         RESP: begin
            if (resp_hs) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
      // Counter saturates so a request accepted on the last allowed cycle still
      // leaves the response phase exactly one cycle to complete.
      if (state_q != IDLE) begin
         wdog_d = wdog_hit ? wdog_q : wdog_q + 1'b1;
         if (wdog_hit && !req_hs && !resp_hs) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= OWN_IFU;
         last_q  <= OWN_LSU;
         wdog_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
      end
   end

   // Fields are forced to zero outside REQ so idle buses carry no stale data.
   always_comb begin
      mreq = '0;
      if (in_req) begin
         if (own_lsu) begin
            mreq.addr  = lsu_addr;
            mreq.wen   = lsu_wen;
            mreq.wdata = lsu_wdata;
            mreq.wmask = lsu_wmask;
         end else begin
            mreq.addr = ifu_addr;
         end
      end
   end

   assign mem_req_valid  = in_req;
   assign mem_addr       = mreq.addr;
   assign mem_wen        = mreq.wen;
   assign mem_wdata      = mreq.wdata;
   assign mem_wmask      = mreq.wmask;
   assign mem_resp_ready = in_resp && owner_resp_ready;

   assign ifu_req_ready  = in_req && !own_lsu && mem_req_ready;
   assign lsu_req_ready  = in_req && own_lsu && mem_req_ready;
   assign ifu_resp_valid = in_resp && !own_lsu && mem_resp_valid;
   assign lsu_resp_valid = in_resp && own_lsu && mem_resp_valid;
   assign ifu_rdata      = (in_resp && !own_lsu) ? mem_rdata : '0;
   assign lsu_rdata      = (in_resp && own_lsu) ? mem_rdata : '0;

   assign err_timeout = err_q;

endmodule

// File: tb/tb_ysyx_25030093_mem_arb.sv
// Bench for ysyx_25030093_mem_arb: directed transactions, a latency-configurable
// memory slave, and a transaction-level model compared against the DUT every cycle.
module tb_ysyx_25030093_mem_arb;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
   logic [31:0] ifu_addr = '0, ifu_rdata;
   logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid, lsu_resp_ready = 1'b0;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
   logic        lsu_wen = 1'b0;
   logic [3:0]  lsu_wmask = '0;
   logic        mem_req_valid, mem_req_ready = 1'b1, mem_wen, mem_resp_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err_timeout;

   int total = 0;
   int bad = 0;

   ysyx_25030093_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : ~a;
   endfunction

   // Memory slave: samples handshakes on negedge, answers resp_lat cycles after the request.
   int          resp_lat = 0;
   int          s_cnt = 0;
   bit          s_pend = 0;
   bit          s_rst = 1, s_req_hs = 0, s_resp_hs = 0;
   logic [31:0] s_addr = '0, p_addr = '0;

   always @(negedge clk) begin
      s_rst     = !rst;
      s_req_hs  = mem_req_valid && mem_req_ready;
      s_resp_hs = mem_resp_valid && mem_resp_ready;
      s_addr    = mem_addr;
   end

   always @(posedge clk) begin
      #1;
      if (s_rst) begin
         s_pend = 0; mem_resp_valid = 1'b0; mem_rdata = '0;
      end else begin
         if (s_resp_hs) begin
            s_pend = 0; mem_resp_valid = 1'b0; mem_rdata = '0;
         end
         if (s_req_hs) begin
            s_pend = 1; s_cnt = resp_lat; p_addr = s_addr;
         end
         if (s_pend && !mem_resp_valid) begin
            if (s_cnt == 0) begin
               mem_resp_valid = 1'b1; mem_rdata = rdata_of(p_addr);
            end else s_cnt--;
         end
      end
   end

   // Transaction-level model: phase 0 idle, 1 address, 2 data; who 0=IFU 1=LSU.
   int m_ph = 0, m_who = 0, m_last = 1, m_age = 0;
   bit m_err = 0, m_known = 0;
   bit e_req, e_rsp, e_lsu, e_done;

   always @(negedge clk) begin
      if (m_known) begin
         e_req = (m_ph == 1);
         e_rsp = (m_ph == 2);
         e_lsu = (m_who == 1);
         chk("mem_req_valid", 64'(mem_req_valid), 64'(e_req));
         chk("req_ready", 64'({ifu_req_ready, lsu_req_ready}),
             64'({e_req && !e_lsu && mem_req_ready, e_req && e_lsu && mem_req_ready}));
         chk("mem_addr", 64'(mem_addr), 64'(e_req ? (e_lsu ? lsu_addr : ifu_addr) : 32'h0));
         chk("mem_wr", 64'({mem_wen, mem_wdata, mem_wmask}),
             64'((e_req && e_lsu) ? {lsu_wen, lsu_wdata, lsu_wmask} : 37'h0));
         chk("resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}),
             64'({e_rsp && !e_lsu && mem_resp_valid, e_rsp && e_lsu && mem_resp_valid}));
         chk("ifu_rdata", 64'(ifu_rdata), 64'((e_rsp && !e_lsu) ? mem_rdata : 32'h0));
         chk("lsu_rdata", 64'(lsu_rdata), 64'((e_rsp && e_lsu) ? mem_rdata : 32'h0));
         chk("mem_resp_ready", 64'(mem_resp_ready),
             64'(e_rsp && (e_lsu ? lsu_resp_ready : ifu_resp_ready)));
         chk("err_timeout", 64'(err_timeout), 64'(m_err));
      end
      if (!rst) begin
         m_ph = 0; m_who = 0; m_last = 1; m_age = 0; m_err = 0; m_known = 1;
      end else if (m_known) begin
         if (m_ph == 0) begin
            if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_RR_EN
               m_who = (m_last == 1) ? 0 : 1;
`else
               m_who = 1;
`endif
               m_ph = 1; m_age = 0;
            end else if (ifu_req_valid || lsu_req_valid) begin
               m_who = lsu_req_valid ? 1 : 0;
               m_ph = 1; m_age = 0;
            end
         end else begin
            e_done = (m_ph == 1) ? mem_req_ready
                   : (mem_resp_valid && ((m_who == 1) ? lsu_resp_ready : ifu_resp_ready));
            if (e_done) begin
               if (m_ph == 2) begin m_last = m_who; m_ph = 0; end
               else m_ph = 2;
               m_age++;
            end else if (m_age >= TO - 1) begin
               m_err = 1; m_ph = 0;
            end else m_age++;
         end
      end
   end

   // Directed stimulus.
   int          order[$];
   int          ifu_wait = 0;
   logic [68:0] cap = '0;
   bit          lsu_done = 0;
   int          viol = 0;
   logic [31:0] d_i, d_l;

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic ifu_txn(input logic [31:0] a, input int bp, output logic [31:0] d);
      int n = 0;
      ifu_addr = a; ifu_req_valid = 1'b1; ifu_resp_ready = 1'b0;
      while (!ifu_req_ready && n < 100) begin tick(); n++; end
      chk("ifu_req_wait", 64'(ifu_req_ready), 64'h1);
      order.push_back(0);
      tick();
      ifu_req_valid = 1'b0; ifu_resp_ready = (bp == 0);
      n = 0;
      while (!ifu_resp_valid && n < 100) begin tick(); n++; end
      chk("ifu_resp_wait", 64'(ifu_resp_valid), 64'h1);
      ifu_wait = n;
      d = ifu_rdata;
      for (int i = 0; i < bp; i++) begin
         #1; chk("bp_hold", 64'(mem_resp_ready), 64'h0);
         tick();
      end
      if (bp > 0) begin
         ifu_resp_ready = 1'b1; #1;
         chk("bp_release", 64'({mem_resp_ready, ifu_resp_valid}), 64'h3);
      end
      tick();
      ifu_resp_ready = 1'b0;
   endtask

   task automatic lsu_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] wm, output logic [31:0] d);
      int n = 0;
      lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
      lsu_req_valid = 1'b1; lsu_resp_ready = 1'b0;
      while (!lsu_req_ready && n < 100) begin tick(); n++; end
      chk("lsu_req_wait", 64'(lsu_req_ready), 64'h1);
      cap = {mem_addr, mem_wen, mem_wdata, mem_wmask};
      order.push_back(1);
      tick();
      lsu_req_valid = 1'b0; lsu_resp_ready = 1'b1;
      n = 0;
      while (!lsu_resp_valid && n < 100) begin tick(); n++; end
      chk("lsu_resp_wait", 64'(lsu_resp_valid), 64'h1);
      d = lsu_rdata;
      tick();
      lsu_resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      rst = 1'b0;
      repeat (2) tick();
      chk("reset_outs", 64'({mem_req_valid, mem_resp_ready, ifu_req_ready, ifu_resp_valid,
                             lsu_req_ready, lsu_resp_valid, err_timeout}), 64'h0);
      rst = 1'b1;
      tick();

      // Tie on the first cycle after reset.
      order.delete();
      resp_lat = 1;
      fork
         ifu_txn(32'h8000_0004, 0, d_i);
         lsu_txn(32'h8000_2000, 1'b0, 32'h0, 4'h0, d_l);
      join
      chk("t2_count", 64'(order.size()), 64'd2);
`ifdef ARB_RR_EN
      chk("t2_first", 64'(order[0]), 64'd0);
      chk("t2_second", 64'(order[1]), 64'd1);
`else
      chk("t2_first", 64'(order[0]), 64'd1);
      chk("t2_second", 64'(order[1]), 64'd0);
`endif
      chk("t2_lsu_data", 64'(d_l), 64'h7FFF_DFFF);
      chk("t2_ifu_data", 64'(d_i), 64'h7FFF_FFFB);

      // Single fetch with two wait cycles.
      resp_lat = 2;
      ifu_txn(32'h8000_0000, 0, d_i);
      chk("t1_rdata", 64'(d_i), 64'h0000_0413);
      chk("t1_wait", 64'(ifu_wait), 64'd2);

      // Store while IFU queues behind it.
      order.delete();
      lsu_done = 0; viol = 0; resp_lat = 1;
      fork
         begin lsu_txn(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, d_l); lsu_done = 1; end
         begin tick(); ifu_txn(32'h8000_0200, 0, d_i); end
         begin
            for (int i = 0; i < 60 && !lsu_done; i++) begin
               if (ifu_req_ready) viol++;
               tick();
            end
         end
      join
      chk("t3_stall", 64'(viol), 64'd0);
      chk("t3_addr", 64'(cap[68:37]), 64'h8000_1000);
      chk("t3_wen", 64'(cap[36]), 64'h1);
      chk("t3_wdata", 64'(cap[35:4]), 64'hDEAD_BEEF);
      chk("t3_wmask", 64'(cap[3:0]), 64'hF);
      chk("t3_order", 64'({order[0][0], order[1][0]}), 64'h2);
      chk("t3_ifu_data", 64'(d_i), 64'h7FFF_FDFF);

      // Response backpressure.
      resp_lat = 1;
      ifu_txn(32'h8000_0500, 5, d_i);
      chk("t4_data", 64'(d_i), 64'h7FFF_FAFF);

      // Hung slave.
      mem_req_ready = 1'b0;
      ifu_addr = 32'h8000_0300; ifu_req_valid = 1'b1;
      n = 0;
      while (!mem_req_valid && n < 10) begin tick(); n++; end
      chk("t5_enter", 64'(mem_req_valid), 64'h1);
      n = 0;
      while (!err_timeout && n < 40) begin tick(); n++; end
      chk("t5_cycles", 64'(n), 64'd16);
      chk("t5_idle", 64'({mem_req_valid, err_timeout}), 64'h1);
      ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      lsu_txn(32'h8000_0400, 1'b0, 32'h0, 4'h0, d_l);
      chk("t5_served", 64'(d_l), 64'h7FFF_FBFF);
      chk("t5_sticky", 64'(err_timeout), 64'h1);

      // Reset in the response phase.
      resp_lat = 8;
      ifu_addr = 32'h8000_0600; ifu_req_valid = 1'b1;
      n = 0;
      while (!ifu_req_ready && n < 10) begin tick(); n++; end
      tick();
      ifu_req_valid = 1'b0;
      tick();
      chk("t6_in_resp", 64'({mem_req_valid, err_timeout}), 64'h1);
      rst = 1'b0;
      tick();
      rst = 1'b1; #1;
      chk("t6_outs", 64'({mem_req_valid, mem_resp_ready, ifu_req_ready, ifu_resp_valid,
                          lsu_req_ready, lsu_resp_valid, err_timeout}), 64'h0);
      chk("t6_data", 64'({mem_addr, ifu_rdata}), 64'h0);
      resp_lat = 0;
      tick();
      lsu_txn(32'h8000_0700, 1'b0, 32'h0, 4'h0, d_l);
      chk("t6_after", 64'(d_l), 64'h7FFF_F8FF);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
